score_display: RTL and testbench

// Downstream consumer of the BCD score-digit counter chain. Drives the 7-segment HEX

---
 rtl/score_pkg.sv | 35 +++
 rtl/seg7_decode.sv | 22 ++
 rtl/score_display.sv | 119 +++++++++++
 tb/tb_score_display.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// ============================================================================
// score_pkg : shared display types, segment constants and digit encoder
// Rev 1.0
// ============================================================================
`default_nettype none

package score_pkg;

  typedef enum logic {PLAY, OVER} disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles render as a dash
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_DASH;
    endcase
    return code;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// ============================================================================
// seg7_decode : one BCD digit plus blank flag -> active-low 7-segment pattern
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_decode
  import score_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) seg = seg_code(digit);
  end

endmodule

`default_nettype wire

// File: rtl/score_display.sv
// ============================================================================
// score_display : live/frozen score on HEX displays, session high score,
//                 blinking on a new record
// Rev 1.0
// ============================================================================
`default_nettype none

module score_display
  import score_pkg::*;
#(
  parameter int NUM_DIGITS   = 3,
  parameter int BLINK_CYCLES = 25_000_000
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         game_over,
  input  logic [4*NUM_DIGITS-1:0]      score_bcd,
  output logic [NUM_DIGITS-1:0][6:0]   HEX,
  output logic [4*NUM_DIGITS-1:0]      high_score,
  output logic                         new_record
);

  localparam int CNT_W = $clog2(BLINK_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(BLINK_CYCLES - 1);

  disp_state_t                   r_state;
  disp_state_t                   w_state_next;
  logic                          r_game_over_q;
  logic [4*NUM_DIGITS-1:0]       r_final;
  logic [CNT_W-1:0]              r_blink_cnt;
  logic                          r_phase_on;

  logic                          w_rise;
  logic                          w_fall;
  logic                          w_blinking;
  logic                          w_blank_all;
  logic [4*NUM_DIGITS-1:0]       w_src;
  logic [NUM_DIGITS-1:0]         w_blank;
  logic [NUM_DIGITS-1:0][6:0]    w_seg;

  assign w_rise      = game_over & ~r_game_over_q;
  assign w_fall      = (r_state == OVER) & ~game_over;
  assign w_blinking  = (r_state == OVER) & new_record;
  assign w_blank_all = w_blinking & ~r_phase_on;
  assign w_src       = (r_state == OVER) ? r_final : score_bcd;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= PLAY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      PLAY:    if (w_rise) w_state_next = OVER;
      OVER:    if (!game_over) w_state_next = PLAY;
      default: w_state_next = PLAY;
    endcase
  end

  // Leading-zero blanking: digit i>0 hides when it and all higher digits are 0
  generate
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      if (i == 0) begin : g_ones
        assign w_blank[i] = w_blank_all;
      end else begin : g_upper
        assign w_blank[i] = w_blank_all | (w_src[4*NUM_DIGITS-1:4*i] == '0);
      end
      seg7_decode u_dec (
        .digit (w_src[4*i +: 4]),
        .blank (w_blank[i]),
        .seg   (w_seg[i])
      );
    end
  endgenerate

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_game_over_q <= 1'b0;
      r_final       <= '0;
      high_score    <= '0;
      new_record    <= 1'b0;
      r_blink_cnt   <= '0;
      r_phase_on    <= 1'b1;
      HEX           <= '{default: SEG_BLANK};
      HEX[0]        <= seg_code(4'd0);
    end else begin
      r_game_over_q <= game_over;
      HEX           <= w_seg;
      if (r_state == PLAY && w_rise) begin
        // Upstream counter clears on this same edge, so score_bcd is still valid
        r_final <= score_bcd;
        if (score_bcd > high_score) begin
          high_score <= score_bcd;
          new_record <= 1'b1;
        end else begin
          new_record <= 1'b0;
        end
      end else if (w_fall) begin
        new_record  <= 1'b0;
        r_blink_cnt <= '0;
        r_phase_on  <= 1'b1;
      end else if (w_blinking) begin
        if (r_blink_cnt == c_cnt_max) begin
          r_blink_cnt <= '0;
          r_phase_on  <= ~r_phase_on;
        end else begin
          r_blink_cnt <= r_blink_cnt + 1'b1;
        end
      end else begin
        r_blink_cnt <= '0;
        r_phase_on  <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_score_display.sv
// ============================================================================
// tb_score_display : directed self-checking bench for score_display
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_score_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] DS = 7'b0111111;

  logic             Clock;
  logic             Reset;
  logic             game_over;
  logic [11:0]      score_bcd;
  logic [2:0][6:0]  HEX;
  logic [11:0]      high_score;
  logic             new_record;

  int checks = 0;
  int errors = 0;

  score_display #(.NUM_DIGITS(3), .BLINK_CYCLES(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .game_over  (game_over),
    .score_bcd  (score_bcd),
    .HEX        (HEX),
    .high_score (high_score),
    .new_record (new_record)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset();
    logic [20:0] exp;
    score_bcd = 12'h123;
    tick();
    exp = {S1, S2, S3};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL pre_reset_hex got %h want %h", HEX, exp);
    end
    #2 Reset = 1'b1;
    #1;
    exp = {BL, BL, S0};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL reset_hex got %h want %h", HEX, exp);
    end
    checks++;
    if (high_score !== 12'h000 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got hs=%h nr=%b want hs=000 nr=0", high_score, new_record);
    end
    #1 Reset = 1'b0;
  endtask

  task automatic test_blanking();
    logic [20:0] exp;
    score_bcd = 12'h007;
    tick();
    exp = {BL, BL, S7};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL blank_007 got %h want %h", HEX, exp);
    end
    score_bcd = 12'h105;
    tick();
    exp = {S1, S0, S5};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL internal_zero_105 got %h want %h", HEX, exp);
    end
    score_bcd = 12'h000;
    tick();
    exp = {BL, BL, S0};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL zero_score got %h want %h", HEX, exp);
    end
  endtask

  task automatic test_record_blink();
    logic [20:0] exp;
    score_bcd = 12'h042;
    tick();
    game_over = 1'b1;
    tick();
    score_bcd = 12'h000;
    checks++;
    if (high_score !== 12'h042 || new_record !== 1'b1) begin
      errors++;
      $display("FAIL record_set got hs=%h nr=%b want hs=042 nr=1", high_score, new_record);
    end
    exp = {BL, S4, S2};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL record_hex0 got %h want %h", HEX, exp);
    end
    // Phase is on for 4 OVER cycles, then off for 4; HEX lags phase by one edge
    for (int k = 1; k <= 12; k++) begin
      tick();
      exp = (k <= 4 || k >= 9) ? {BL, S4, S2} : {BL, BL, BL};
      checks++;
      if (HEX !== exp || new_record !== 1'b1) begin
        errors++;
        $display("FAIL blink_k%0d got hex=%h nr=%b want hex=%h nr=1", k, HEX, new_record, exp);
      end
    end
  endtask

  task automatic test_no_record();
    logic [20:0] exp;
    game_over = 1'b0;
    tick();
    checks++;
    if (new_record !== 1'b0) begin
      errors++;
      $display("FAIL fall_clears_nr got %b want 0", new_record);
    end
    score_bcd = 12'h017;
    tick();
    game_over = 1'b1;
    tick();
    score_bcd = 12'h000;
    checks++;
    if (high_score !== 12'h042 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL lower_score got hs=%h nr=%b want hs=042 nr=0", high_score, new_record);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      exp = {BL, S1, S7};
      checks++;
      if (HEX !== exp) begin
        errors++;
        $display("FAIL steady_17_k%0d got %h want %h", k, HEX, exp);
      end
    end
    game_over = 1'b0;
    tick();
    score_bcd = 12'h042;
    tick();
    game_over = 1'b1;
    tick();
    score_bcd = 12'h000;
    checks++;
    if (high_score !== 12'h042 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL equal_score got hs=%h nr=%b want hs=042 nr=0", high_score, new_record);
    end
    tick();
    tick();
    exp = {BL, S4, S2};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL equal_steady got %h want %h", HEX, exp);
    end
  endtask

  task automatic test_dash();
    logic [20:0] exp;
    game_over = 1'b0;
    tick();
    score_bcd = 12'h00A;
    tick();
    exp = {BL, BL, DS};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL dash_00A got %h want %h", HEX, exp);
    end
    score_bcd = 12'h1A3;
    tick();
    exp = {S1, DS, S3};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL dash_1A3 got %h want %h", HEX, exp);
    end
  endtask

  task automatic test_reset_mid_blink();
    logic [20:0] exp;
    score_bcd = 12'h099;
    tick();
    game_over = 1'b1;
    tick();
    score_bcd = 12'h000;
    checks++;
    if (high_score !== 12'h099 || new_record !== 1'b1) begin
      errors++;
      $display("FAIL record_099 got hs=%h nr=%b want hs=099 nr=1", high_score, new_record);
    end
    for (int k = 0; k < 6; k++) tick();
    #2 Reset = 1'b1;
    #1;
    exp = {BL, BL, S0};
    checks++;
    if (HEX !== exp || high_score !== 12'h000 || new_record !== 1'b0) begin
      errors++;
      $display("FAIL mid_blink_reset got hex=%h hs=%h nr=%b want hex=%h hs=000 nr=0",
               HEX, high_score, new_record, exp);
    end
    game_over = 1'b0;
    score_bcd = 12'h023;
    #1 Reset = 1'b0;
    tick();
    exp = {BL, S2, S3};
    checks++;
    if (HEX !== exp) begin
      errors++;
      $display("FAIL after_reset_live got %h want %h", HEX, exp);
    end
    score_bcd = 12'h150;
    tick();
    exp = {S1, S5, S0};
    checks++;
    if (HEX !== exp || new_record !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_play got hex=%h nr=%b want hex=%h nr=0", HEX, new_record, exp);
    end
  endtask

  initial begin
    Reset     = 1'b1;
    game_over = 1'b0;
    score_bcd = 12'h000;
    #12 Reset = 1'b0;
    test_reset();
    test_blanking();
    test_record_blink();
    test_no_record();
    test_dash();
    test_reset_mid_blink();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
